powlib_cntr: RTL and testbench

//  Single-clock up-counter with synchronous clear, optional parallel load and programmable wrap point.

---
 rtl/powlib_cntr.sv | 83 ++++++++
 tb/tb_powlib_cntr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/powlib_cntr.sv
// powlib_cntr: single-clock up-counter with synchronous clear, optional saturating load
// and programmable wrap point. Optional simulation checks under `define POWLIB_CNTR_DBG_EN.
module powlib_cntr #(
    parameter int unsigned      W    = 4,
    parameter logic [W-1:0]     INIT = '0,
    parameter bit               ELD  = 1'b1,
    parameter logic [W-1:0]     MAX  = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cntr,
    input  logic         adv,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] nval,
    output logic         tc
);

    // adv is a single-cycle strobe: every cycle it is high while clr/ld are low
    // counts exactly one event; there is no back-pressure.
    logic [W-1:0] cntr_q;
    logic [W-1:0] cntr_nxt;
    logic [W-1:0] ld_val;
    logic         ld_en;
    logic         at_max;

    assign at_max = (cntr_q == MAX);

    generate
        if (ELD) begin : g_load
            assign ld_en  = ld;
            // Loads above the wrap point clamp to MAX so the counter stays in range.
            assign ld_val = (nval > MAX) ? MAX : nval;
        end else begin : g_noload
            logic unused_ld;
            assign unused_ld = ^{ld, nval};
            assign ld_en     = 1'b0;
            assign ld_val    = '0;
        end
    endgenerate

    // Priority below rst: clr > ld > adv > hold. Wrap returns to 0, not INIT.
    always_comb begin
        cntr_nxt = cntr_q;
        if (clr) begin
            cntr_nxt = INIT;
        end else if (ld_en) begin
            cntr_nxt = ld_val;
        end else if (adv) begin
            cntr_nxt = at_max ? '0 : cntr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr_q <= INIT;
        end else begin
            cntr_q <= cntr_nxt;
        end
    end

    assign cntr = cntr_q;
    assign tc   = at_max;

`ifdef POWLIB_CNTR_DBG_EN
    initial begin
        if ((INIT > MAX) || (W < 1)) begin
            $display("%m: illegal parameters W=%0d INIT=%0d MAX=%0d", W, INIT, MAX);
            $finish;
        end
    end

    always @(posedge clk) begin
        if (!rst && !clr && !ld_en && adv && at_max) begin
            $display("%m wrap");
        end
        if (!ELD && ld) begin
            $display("%m warning: ld asserted while load path is disabled");
        end
    end
`endif

endmodule

// File: tb/tb_powlib_cntr.sv
// Directed bench for powlib_cntr: four configurations, driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares against the DUT.
module tb_powlib_cntr;

    logic clk;
    logic       rst_v  [4];
    logic       adv_v  [4];
    logic       clr_v  [4];
    logic       ld_v   [4];
    logic [3:0] nval_v [4];

    logic [3:0] cntr0, cntr1, cntr2;
    logic [2:0] cntr3;
    logic       tc0, tc1, tc2, tc3;

    // expected entry: [7:6] instance id, [4] tc, [3:0] cntr
    logic [7:0] exp_q[$];
    int n_checks;
    int n_fail;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    // 0: INIT=3 MAX=5 with load; 1: INIT=0 MAX=5; 2: no load path; 3: W=3 natural wrap
    powlib_cntr #(.W(4), .INIT(4'd3), .ELD(1'b1), .MAX(4'd5)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .cntr(cntr0), .adv(adv_v[0]), .clr(clr_v[0]),
        .ld(ld_v[0]), .nval(nval_v[0]), .tc(tc0));

    powlib_cntr #(.W(4), .INIT(4'd0), .ELD(1'b1), .MAX(4'd5)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .cntr(cntr1), .adv(adv_v[1]), .clr(clr_v[1]),
        .ld(ld_v[1]), .nval(nval_v[1]), .tc(tc1));

    powlib_cntr #(.W(4), .INIT(4'd0), .ELD(1'b0), .MAX(4'd15)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .cntr(cntr2), .adv(adv_v[2]), .clr(clr_v[2]),
        .ld(ld_v[2]), .nval(nval_v[2]), .tc(tc2));

    powlib_cntr #(.W(3), .INIT(3'd0), .ELD(1'b1), .MAX(3'd7)) u_dut3 (
        .clk(clk), .rst(rst_v[3]), .cntr(cntr3), .adv(adv_v[3]), .clr(clr_v[3]),
        .ld(ld_v[3]), .nval(nval_v[3][2:0]), .tc(tc3));

    // Driver: one cycle of stimulus on instance id, then queue what it must show.
    task automatic step(input int id, input logic r, input logic a, input logic c,
                        input logic l, input logic [3:0] nv,
                        input logic [3:0] exp_c, input logic exp_tc);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b0; adv_v[i] = 1'b0; clr_v[i] = 1'b0; ld_v[i] = 1'b0; nval_v[i] = 4'd0;
        end
        rst_v[id] = r; adv_v[id] = a; clr_v[id] = c; ld_v[id] = l; nval_v[id] = nv;
        @(posedge clk);
        #1;
        exp_q.push_back({2'(id), 1'b0, exp_tc, exp_c});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        logic [3:0] act_c;
        logic       act_t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e[7:6])
                2'd0:    begin act_c = cntr0;         act_t = tc0; end
                2'd1:    begin act_c = cntr1;         act_t = tc1; end
                2'd2:    begin act_c = cntr2;         act_t = tc2; end
                default: begin act_c = {1'b0, cntr3}; act_t = tc3; end
            endcase
            n_checks++;
            if ((act_c !== e[3:0]) || (act_t !== e[4])) begin
                n_fail++;
                $display("FAIL dut%0d cntr/tc: got cntr=%0d tc=%b, expected cntr=%0d tc=%b",
                         e[7:6], act_c, act_t, e[3:0], e[4]);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1; adv_v[i] = 1'b0; clr_v[i] = 1'b0; ld_v[i] = 1'b0; nval_v[i] = 4'd0;
        end
        repeat (2) @(posedge clk);

        // reset values of every instance (dut0 held in reset with adv active)
        step(0, 1, 1, 0, 0, 4'd0, 4'd3, 1'b0);
        step(0, 1, 0, 0, 0, 4'd0, 4'd3, 1'b0);
        step(1, 1, 0, 0, 0, 4'd0, 4'd0, 1'b0);
        step(2, 1, 0, 0, 0, 4'd0, 4'd0, 1'b0);
        step(3, 1, 0, 0, 0, 4'd0, 4'd0, 1'b0);
        // idle hold
        step(0, 0, 0, 0, 0, 4'd0, 4'd3, 1'b0);
        step(0, 0, 0, 0, 0, 4'd9, 4'd3, 1'b0);

        // programmable wrap at MAX=5
        step(1, 0, 1, 0, 0, 4'd0, 4'd1, 1'b0);
        step(1, 0, 1, 0, 0, 4'd0, 4'd2, 1'b0);
        step(1, 0, 1, 0, 0, 4'd0, 4'd3, 1'b0);
        step(1, 0, 1, 0, 0, 4'd0, 4'd4, 1'b0);
        step(1, 0, 1, 0, 0, 4'd0, 4'd5, 1'b1);
        step(1, 0, 1, 0, 0, 4'd0, 4'd0, 1'b0);
        step(1, 0, 1, 0, 0, 4'd0, 4'd1, 1'b0);

        // simultaneous events on dut0 (INIT=3, MAX=5)
        step(0, 0, 1, 0, 0, 4'd0, 4'd4, 1'b0);
        step(0, 0, 1, 1, 1, 4'd9, 4'd3, 1'b0);
        step(0, 0, 1, 0, 1, 4'd9, 4'd5, 1'b1);
        step(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b0);
        step(0, 0, 0, 0, 1, 4'd2, 4'd2, 1'b0);
        step(0, 0, 1, 0, 0, 4'd0, 4'd3, 1'b0);
        step(0, 0, 0, 0, 1, 4'd5, 4'd5, 1'b1);
        step(0, 0, 0, 1, 0, 4'd0, 4'd3, 1'b0);

        // reset mid-count discards adv
        step(0, 0, 1, 0, 0, 4'd0, 4'd4, 1'b0);
        step(0, 0, 1, 0, 0, 4'd0, 4'd5, 1'b1);
        step(0, 1, 1, 0, 0, 4'd0, 4'd3, 1'b0);
        step(0, 0, 1, 0, 0, 4'd0, 4'd4, 1'b0);
        step(0, 0, 1, 0, 0, 4'd0, 4'd5, 1'b1);

        // load path absent
        step(2, 0, 1, 0, 0, 4'd0, 4'd1, 1'b0);
        step(2, 0, 0, 0, 1, 4'd7, 4'd1, 1'b0);
        step(2, 0, 1, 0, 1, 4'd7, 4'd2, 1'b0);
        step(2, 0, 0, 1, 0, 4'd0, 4'd0, 1'b0);

        // W=3 natural wrap
        step(3, 0, 0, 0, 1, 4'd6, 4'd6, 1'b0);
        step(3, 0, 1, 0, 0, 4'd0, 4'd7, 1'b1);
        step(3, 0, 1, 0, 0, 4'd0, 4'd0, 1'b0);
        step(3, 0, 1, 0, 0, 4'd0, 4'd1, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            adv_v[i] = 1'b0; clr_v[i] = 1'b0; ld_v[i] = 1'b0;
        end
        for (int i = 0; (i < 10) && (exp_q.size() > 0); i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
